rom_rr_arbiter: RTL and testbench

//   Shares one synchronous 16x4 read-only memory (ports clk/en/addr/data) between
//   NUM_REQ independent read requesters. Round-robin arbitration, one read in flight.

---
 rtl/rom_arb_pkg.sv | 18 +
 rtl/rom_rr_pick.sv | 38 +++
 rtl/rom_rr_arbiter.sv | 117 +++++++++++
 tb/tb_rom_rr_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// rom_arb_pkg -- shared state encoding and default widths for the ROM arbiter
// Revision: 1.0
// ============================================================================
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

endpackage
`default_nettype wire

// File: rtl/rom_rr_pick.sv
`default_nettype none
// ============================================================================
// rom_rr_pick -- combinational round-robin winner search starting at ptr
// Revision: 1.0
// ============================================================================
module rom_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               any,
  output logic [PTR_W-1:0]   winner
);

  // One extra bit so ptr+i never overflows before the modulo fold.
  logic [PTR_W:0] idx;
  logic           found;

  always_comb begin
    any    = |req;
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) begin
        idx = idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req[idx[PTR_W-1:0]]) begin
        winner = idx[PTR_W-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rom_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rom_rr_arbiter -- round-robin sharing of one synchronous ROM, one read in flight
// Revision: 1.0
// ============================================================================
module rom_rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data
);

  localparam int PTR_W = $clog2(NUM_REQ);

  state_t               state, state_n;
  logic [PTR_W-1:0]     ptr, ptr_n;
  logic [PTR_W-1:0]     cur, cur_n;
  logic [NUM_REQ-1:0]   gnt_n, rvalid_n;
  logic                 rom_en_n;
  logic [ADDR_W-1:0]    rom_addr_n;

  logic                 any;
  logic [PTR_W-1:0]     winner;
  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  rom_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  assign rdata = rom_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cur      <= '0;
      gnt      <= '0;
      rvalid   <= '0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cur      <= cur_n;
      gnt      <= gnt_n;
      rvalid   <= rvalid_n;
      rom_en   <= rom_en_n;
      rom_addr <= rom_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    cur_n      = cur;
    gnt_n      = gnt;
    rvalid_n   = rvalid;
    rom_en_n   = rom_en;
    rom_addr_n = rom_addr;
    unique case (state)
      IDLE: begin
        if (any) begin
          cur_n      = winner;
          gnt_n      = NUM_REQ'(1) << winner;
          rom_addr_n = addr_arr[winner];
          rom_en_n   = 1'b1;
          state_n    = READ;
        end
      end
      READ: begin
        // ROM samples addr on this closing edge; its word appears during RESP.
        rom_en_n = 1'b0;
        rvalid_n = gnt;
        state_n  = RESP;
      end
      RESP: begin
        rvalid_n = '0;
        gnt_n    = '0;
        ptr_n    = (cur == PTR_W'(NUM_REQ-1)) ? '0 : cur + PTR_W'(1);
        state_n  = IDLE;
      end
      default: begin
        state_n  = IDLE;
        gnt_n    = '0;
        rvalid_n = '0;
        rom_en_n = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rom_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rom_rr_arbiter -- directed self-checking bench with a mem[a] = ~a ROM model
// Revision: 1.0
// ============================================================================
module tb_rom_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] req_addr = '0;
  logic [3:0]  gnt, rvalid, rdata, rom_addr, rom_data;
  logic        rom_en;
  logic [3:0]  rom_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rom_en) rom_q <= ~rom_addr;
  end
  assign rom_data = rom_q;

  rom_rr_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_d2 [4] = '{4'hE, 4'hD, 4'hC, 4'hB};
  logic [3:0] exp_g3 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  initial begin
    // Reset state
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_rom_addr", rom_addr, 4'h0);
    rst = 1'b0;

    // 1: single read
    req = 4'b0001; req_addr[3:0] = 4'hA;
    step();
    chk("t1_gnt", gnt, 4'b0001);
    chk("t1_rom_en", rom_en, 1'b1);
    chk("t1_rom_addr", rom_addr, 4'hA);
    chk("t1_rvalid_early", rvalid, 4'b0000);
    req = 4'b0000;
    step();
    chk("t1_rvalid", rvalid, 4'b0001);
    chk("t1_rdata", rdata, 4'h5);
    chk("t1_rom_en_off", rom_en, 1'b0);
    step();
    chk("t1_gnt_off", gnt, 4'b0000);
    chk("t1_rvalid_off", rvalid, 4'b0000);

    // 2: all four from ptr=0
    rst = 1'b1; step(); rst = 1'b0;
    req_addr = {4'h4, 4'h3, 4'h2, 4'h1};
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t2_gnt", gnt, 4'b0001 << k);
      chk("t2_rom_addr", rom_addr, 4'(k + 1));
      step();
      chk("t2_rvalid", rvalid, 4'b0001 << k);
      chk("t2_rdata", rdata, exp_d2[k]);
      step();
      chk("t2_idle_gnt", gnt, 4'b0000);
    end
    req = 4'b0000;

    // 3: two contenders alternate
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_gnt", gnt, exp_g3[k]);
      step();
      chk("t3_rvalid", rvalid, exp_g3[k]);
      step();
    end
    req = 4'b0000;

    // 4: reset mid-READ (ptr=3, so 3 wins first; after reset 1 must win)
    req_addr[7:4] = 4'h7; req_addr[15:12] = 4'h2;
    req = 4'b1010;
    step();
    chk("t4_gnt_pre", gnt, 4'b1000);
    rst = 1'b1;
    #1;
    chk("t4_async_gnt", gnt, 4'b0000);
    chk("t4_async_rom_en", rom_en, 1'b0);
    chk("t4_async_rvalid", rvalid, 4'b0000);
    step();
    chk("t4_no_rvalid", rvalid, 4'b0000);
    rst = 1'b0;
    step();
    chk("t4_gnt_post", gnt, 4'b0010);
    chk("t4_rom_addr", rom_addr, 4'h7);
    req = 4'b0000;
    step();
    chk("t4_rvalid", rvalid, 4'b0010);
    chk("t4_rdata", rdata, 4'h8);
    step();

    // 5: req0 dropped during READ (ptr=2)
    req_addr[3:0] = 4'h9;
    req = 4'b0001;
    step();
    chk("t5_gnt", gnt, 4'b0001);
    req = 4'b0000;
    step();
    chk("t5_rvalid", rvalid, 4'b0001);
    chk("t5_rdata", rdata, 4'h6);
    step();
    req = 4'b0011;
    step();
    chk("t5_next_gnt", gnt, 4'b0010);
    req = 4'b0000;
    step(); step();

    // 6: wrap 3 -> 0, rom_addr stable while idle
    req_addr[15:12] = 4'hC;
    req = 4'b1000;
    step();
    chk("t6_gnt3", gnt, 4'b1000);
    chk("t6_rom_addr3", rom_addr, 4'hC);
    req = 4'b1001;
    step();
    chk("t6_rvalid3", rvalid, 4'b1000);
    chk("t6_rdata3", rdata, 4'h3);
    chk("t6_addr_hold_resp", rom_addr, 4'hC);
    step();
    chk("t6_idle_gnt", gnt, 4'b0000);
    chk("t6_addr_hold_idle", rom_addr, 4'hC);
    chk("t6_idle_rom_en", rom_en, 1'b0);
    step();
    chk("t6_gnt0", gnt, 4'b0001);
    chk("t6_rom_addr0", rom_addr, 4'h9);
    req = 4'b0000;
    step();
    chk("t6_rdata0", rdata, 4'h6);
    step();
    chk("t6_final_gnt", gnt, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
